// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the muldiv_seq unit.
interface muldiv_seq_if #(parameter int XLEN = 32) ();
    logic            start_i;
    logic [4:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [4:0]      rd_i;
    logic            flush_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] res_o;
    logic [4:0]      rd_o;

    modport master (output start_i, op_i, a_i, b_i, rd_i, flush_i,
                    input  busy_o, valid_o, res_o, rd_o);
    modport slave  (input  start_i, op_i, a_i, b_i, rd_i, flush_i,
                    output busy_o, valid_o, res_o, rd_o);
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M unit: radix-2 restoring divider, MUL family single-cycle
// unless MULDIV_SEQ_MUL_EN is defined, which routes it through a 32-step shift-add.
module muldiv_seq #(parameter int XLEN = 32) (
    input  logic           clk_i,
    input  logic           rst_ni,
    muldiv_seq_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            is_mul_q, is_mul_d;
    logic            is_rem_q, is_rem_d;
    logic            hi_q, hi_d;
    logic            neg_q, neg_d;
    logic [4:0]      tag_q, tag_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [4:0]      rd_q, rd_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;

    logic            a_neg_s, b_neg_s, b_zero_s, ovf_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s;
    logic [XLEN:0]   shifted_s, diff_s, sum_s;
    logic [XLEN-1:0] rem_step_s, quo_step_s, div_r_s, div_fin_s, mul_fin_s, fin_s;
    logic [63:0]     prod_full_s, prod_fin_s;
`ifdef MULDIV_SEQ_MUL_EN
    logic            ma_neg_s, mb_neg_s;
`else
    logic signed [63:0] pa_s, pb_s, prod_s;
`endif

    // Launch-time operand decode: signed magnitudes and the short-cut cases.
    always_comb begin
        a_neg_s  = ~bus.op_i[0] & bus.a_i[31];
        b_neg_s  = ~bus.op_i[0] & bus.b_i[31];
        a_mag_s  = a_neg_s ? (32'd0 - bus.a_i) : bus.a_i;
        b_mag_s  = b_neg_s ? (32'd0 - bus.b_i) : bus.b_i;
        b_zero_s = (bus.b_i == 32'd0);
        ovf_s    = ~bus.op_i[0] & (bus.a_i == 32'h8000_0000) & (bus.b_i == 32'hFFFF_FFFF);
`ifdef MULDIV_SEQ_MUL_EN
        ma_neg_s = ((bus.op_i[1:0] == 2'b01) | (bus.op_i[1:0] == 2'b10)) & bus.a_i[31];
        mb_neg_s = (bus.op_i[1:0] == 2'b01) & bus.b_i[31];
`else
        pa_s   = {{32{(bus.op_i[1:0] != 2'b11) & bus.a_i[31]}}, bus.a_i};
        pb_s   = {{32{(bus.op_i[1:0] == 2'b01) & bus.b_i[31]}}, bus.b_i};
        prod_s = pa_s * pb_s;
`endif
    end

    // One iteration of either datapath plus the sign-corrected final result.
    always_comb begin
        shifted_s = {rem_q, quo_q[31]};
        diff_s    = shifted_s - {1'b0, dvs_q};
        sum_s     = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : 33'd0);
        if (is_mul_q) begin
            rem_step_s = sum_s[32:1];
            quo_step_s = {sum_s[0], quo_q[31:1]};
        end else begin
            rem_step_s = diff_s[32] ? shifted_s[31:0] : diff_s[31:0];
            quo_step_s = {quo_q[30:0], ~diff_s[32]};
        end
        div_r_s     = is_rem_q ? rem_step_s : quo_step_s;
        div_fin_s   = neg_q ? (32'd0 - div_r_s) : div_r_s;
        prod_full_s = {rem_step_s, quo_step_s};
        prod_fin_s  = neg_q ? (64'd0 - prod_full_s) : prod_full_s;
        mul_fin_s   = hi_q ? prod_fin_s[63:32] : prod_fin_s[31:0];
        fin_s       = is_mul_q ? mul_fin_s : div_fin_s;
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_mul_d = is_mul_q;
        is_rem_d = is_rem_q;
        hi_d     = hi_q;
        neg_d    = neg_q;
        tag_d    = tag_q;
        res_d    = res_q;
        rd_d     = rd_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else if (bus.start_i) begin
                    tag_d    = bus.rd_i;
                    cnt_d    = 5'd0;
                    is_mul_d = 1'b0;
                    is_rem_d = bus.op_i[1];
                    if (bus.op_i[4:3] != 2'b10) begin
                        state_d = S_DONE;
                        res_d   = 32'd0;
                        rd_d    = bus.rd_i;
                    end else if (bus.op_i[2]) begin
                        neg_d = bus.op_i[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
                        if (b_zero_s) begin
                            state_d = S_DONE;
                            res_d   = bus.op_i[1] ? bus.a_i : 32'hFFFF_FFFF;
                            rd_d    = bus.rd_i;
                        end else if (ovf_s) begin
                            state_d = S_DONE;
                            res_d   = bus.op_i[1] ? 32'd0 : 32'h8000_0000;
                            rd_d    = bus.rd_i;
                        end else begin
                            state_d = S_RUN;
                            rem_d   = 32'd0;
                            quo_d   = a_mag_s;
                            dvs_d   = b_mag_s;
                        end
                    end else begin
`ifdef MULDIV_SEQ_MUL_EN
                        // hi accumulates in rem, multiplier shifts out of quo
                        state_d  = S_RUN;
                        is_mul_d = 1'b1;
                        hi_d     = (bus.op_i[1:0] != 2'b00);
                        neg_d    = ma_neg_s ^ mb_neg_s;
                        rem_d    = 32'd0;
                        quo_d    = mb_neg_s ? (32'd0 - bus.b_i) : bus.b_i;
                        dvs_d    = ma_neg_s ? (32'd0 - bus.a_i) : bus.a_i;
`else
                        state_d = S_DONE;
                        res_d   = (bus.op_i[1:0] != 2'b00) ? prod_s[63:32] : prod_s[31:0];
                        rd_d    = bus.rd_i;
`endif
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_step_s;
                    quo_d = quo_step_s;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_DONE;
                        res_d   = fin_s;
                        rd_d    = tag_q;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d  = (state_d == S_RUN);
        valid_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            is_mul_q <= 1'b0;
            is_rem_q <= 1'b0;
            hi_q     <= 1'b0;
            neg_q    <= 1'b0;
            tag_q    <= 5'd0;
            res_q    <= 32'd0;
            rd_q     <= 5'd0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_mul_q <= is_mul_d;
            is_rem_q <= is_rem_d;
            hi_q     <= hi_d;
            neg_q    <= neg_d;
            tag_q    <= tag_d;
            res_q    <= res_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.valid_o = valid_q;
    assign bus.res_o   = res_q;
    assign bus.rd_o    = rd_q;
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle RV32M execute unit that sits beside the single-cycle ALU in the execute stage and produces results for the EX/MEM register. Takes operands and the 5-bit ALU op code from the ID/EX register, runs a radix-2 restoring divider (and optionally a shift-add multiplier), and drives a busy signal that stalls the front of the pipeline while an operation is in flight. It removes the combinational divide/remainder path from the execute stage's critical timing.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk_i`  input  1  clock, rising edge.
- `rst_ni`  input  1  reset, asynchronous, active-low.
- `start_i`  input  1  launch request; sampled only when `busy_o`=0.
- `op_i`  input  5  op code: 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- `a_i`  input  32  rs1 operand.
- `b_i`  input  32  rs2 operand.
- `rd_i`  input  5  destination register tag, carried with the operation.
- `flush_i`  input  1  kill the in-flight operation.
- `busy_o`  output  1  operation in flight; pipeline must stall.
- `valid_o`  output  1  one-cycle result strobe.
- `res_o`  output  32  result, qualified by `valid_o`.
- `rd_o`  output  5  destination tag of `res_o`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + `start_i` with no `flush_i`: latch op, operands and `rd_i`, then classify:
  - Normal divide/remainder -> RUN with iteration count 0.
  - Short-cut cases -> DONE directly.
  - MUL ops (macro off) -> DONE directly.
- RUN: one quotient bit per edge on magnitudes. After 32 iterations -> DONE.
- DONE: `valid_o`=1 for exactly one cycle, then IDLE, or a new launch if `start_i`=1.
- Signed DIV/REM:
  - Operate on absolute values.
  - Quotient negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Short cuts, all 1-cycle:
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> `a_i`.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- MUL family: 64-bit product.
  - MUL returns bits [31:0].
  - MULH is signed x signed, MULHSU is signed x unsigned, MULHU is unsigned x unsigned; all three return bits [63:32].
- Op codes outside 10000-10111: result 0, 1-cycle latency.
- `flush_i`: next state IDLE from any state, and `valid_o` is suppressed. If `flush_i` and `start_i` are both high, the flush wins and the start is dropped.
- `res_o` and `rd_o` update only on entry to DONE and hold between results.

## Timing
- Reset (`rst_ni`=0, asynchronous): state IDLE, `busy_o`=0, `valid_o`=0, `res_o`=0, `rd_o`=0, count 0. Reset mid-RUN aborts the operation with no `valid_o`.
- `busy_o`=1 exactly while in RUN; it is registered and glitch-free.
- Launch edge = the edge that samples `start_i`.
- Short-cut, default-op and MUL (macro off): `valid_o` high in the cycle immediately after the launch edge, with `busy_o` never asserted.
- Normal divide: `busy_o` high for 32 cycles after the launch edge, then `valid_o` high in the 33rd cycle. Total latency is 33 cycles.
- Back-to-back: `start_i` during the DONE cycle is accepted. The new operation's `busy_o` or `valid_o` follows with no bubble.
- `start_i` while `busy_o`=1 is ignored.

## Configuration
- `MULDIV_SEQ_MUL_EN` defined:
  - MUL-family ops also use the RUN state with a 32-iteration shift-add on magnitudes.
  - The 64-bit result is negated per signedness.
  - Same 33-cycle latency and `busy_o` profile as divide.
  - No hardware multiplier is inferred.
- `MULDIV_SEQ_MUL_EN` undefined:
  - MUL-family ops compute a single-cycle combinational 64-bit product, registered at the launch edge.
  - Latency 1, `busy_o` never asserted.

## Test plan
- DIVU 100 / 7, `rd_i`=5 -> `busy_o` high for 32 cycles, `valid_o` in cycle 33 with `res_o`=14 and `rd_o`=5; REMU with the same operands -> 2.
- DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 / 2 -> 0xFFFFFFFF (-1); DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with 1-cycle latency.
- DIVU 5 / 0 -> 0xFFFFFFFF; REM 0x1234 / 0 -> 0x1234; both 1-cycle with no `busy_o`.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0; MULHU of the same operands -> 0xFFFFFFFE; MUL -> 1. Run once with and once without `MULDIV_SEQ_MUL_EN` and check latency 33 vs 1.
- Start DIVU, assert `flush_i` at iteration 10 -> IDLE next cycle, no `valid_o`. A new DIVU 9/3 launched the following cycle returns 3.
- Deassert `rst_ni` at iteration 20 -> all outputs 0 immediately. Launch in the DONE cycle -> back-to-back results, with the `start_i` pulses issued while busy ignored.
